// File: rtl/audio_pkg.sv
// ============================================================================
// Module   : audio_pkg
// Brief    : Shared audio types, FSM state encoding and default constants
//            for the I2S transmit path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int AUDIO_WS_DFLT = 16;  // sample width
    localparam int SLOT_WS_DFLT  = 16;  // BCLKs per channel slot
    localparam int BCLK_DIV_DFLT = 16;  // system clocks per BCLK half-period

    typedef logic signed [AUDIO_WS_DFLT-1:0] audio_t;

    typedef struct packed {
        audio_t l;
        audio_t r;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_master_tx_if.sv
// ============================================================================
// Module   : i2s_master_tx_if
// Brief    : Valid/ready sample bus between the DSP output and the I2S
//            transmitter. master = sample source, slave = transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i2s_master_tx_if #(
    parameter int AUDIO_WS = audio_pkg::AUDIO_WS_DFLT
) ();
    import audio_pkg::*;

    logic                       iValid;
    logic                       oReady;
    logic signed [AUDIO_WS-1:0] iL;
    logic signed [AUDIO_WS-1:0] iR;

    modport master (output iValid, output iL, output iR, input  oReady);
    modport slave  (input  iValid, input  iL, input  iR, output oReady);

endinterface

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module   : i2s_clk_gen
// Brief    : Bit-clock divider for an I2S master. Produces BCLK, a one-cycle
//            strobe marking the cycle whose clock edge drives BCLK low, and
//            the frame bit counter that advances on every BCLK falling edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen #(
    parameter  int SLOT_WS  = audio_pkg::SLOT_WS_DFLT,
    parameter  int BCLK_DIV = audio_pkg::BCLK_DIV_DFLT,
    localparam int CNT_W    = $clog2(2*SLOT_WS),
    localparam int DIV_W    = $clog2(BCLK_DIV)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             run,
    output logic                  bclk,
    output logic                  fall,
    output logic [CNT_W-1:0]      bit_cnt
);
    import audio_pkg::*;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BCLK_DIV-1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(2*SLOT_WS-1);

    logic [DIV_W-1:0] r_div;
    logic             w_term;

    assign w_term = (r_div == c_div_last);
    // Fall is asserted in the cycle whose closing edge takes BCLK from 1 to 0
    assign fall   = run && w_term && bclk;

    // Divider, BCLK toggle and bit counter; everything held cleared while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (!run) begin
            r_div   <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (w_term) begin
            r_div <= '0;
            bclk  <= ~bclk;
            if (bclk) begin
                bit_cnt <= (bit_cnt == c_cnt_last) ? '0 : bit_cnt + CNT_W'(1);
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2s_master_tx.sv
// ============================================================================
// Module   : i2s_master_tx
// Brief    : I2S bus-master transmitter for a slave-mode DAC. Generates
//            BCLK/LRCK from the system clock and serialises stereo frames
//            taken from a one-deep holding register fed by valid/ready.
//            Build option I2S_UNDERRUN_REPEAT_EN: on underrun, resend the
//            last transmitted frame instead of silence.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_master_tx #(
    parameter int AUDIO_WS = audio_pkg::AUDIO_WS_DFLT,
    parameter int SLOT_WS  = audio_pkg::SLOT_WS_DFLT,
    parameter int BCLK_DIV = audio_pkg::BCLK_DIV_DFLT
) (
    input  wire logic           iCLK_50,
    input  wire logic           iRST_N,
    input  wire logic           iEnable,
    i2s_master_tx_if.slave      bus,
    output logic                oBCLK,
    output logic                oLRCK,
    output logic                oDAT,
    output logic                oFrameStart,
    output logic                oUnderrun
);
    import audio_pkg::*;

    localparam int               FRAME_W    = 2*SLOT_WS;
    localparam int               CNT_W      = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FRAME_W-1);
    localparam logic [CNT_W-1:0] c_cnt_slot = CNT_W'(SLOT_WS);

    i2s_state_t                 r_state;
    logic                       r_lrck;
    logic                       r_dat;
    logic [FRAME_W-1:0]         r_shift;
    logic                       r_frame_start;
    logic                       r_underrun;
    logic                       r_full;
    logic                       r_ready;
    logic signed [AUDIO_WS-1:0] r_hold_l;
    logic signed [AUDIO_WS-1:0] r_hold_r;
`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [FRAME_W-1:0]         r_last;
`endif

    logic                       w_run;
    logic                       w_fall;
    logic [CNT_W-1:0]           w_bit_cnt;
    logic                       w_last;
    logic [CNT_W-1:0]           w_cnt_next;
    logic                       w_load;
    logic                       w_stop;
    logic                       w_accept;
    logic [FRAME_W-1:0]         w_frame_hold;
    logic [FRAME_W-1:0]         w_payload;

    assign w_run = (r_state != IDLE);

    i2s_clk_gen #(
        .SLOT_WS  (SLOT_WS),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk     (iCLK_50),
        .rst_n   (iRST_N),
        .run     (w_run),
        .bclk    (oBCLK),
        .fall    (w_fall),
        .bit_cnt (w_bit_cnt)
    );

    assign w_last     = (w_bit_cnt == c_cnt_last);
    assign w_cnt_next = w_last ? '0 : w_bit_cnt + CNT_W'(1);
    // Load on the falling edge that moves the bit counter from 0 to 1
    assign w_load     = w_fall && (w_bit_cnt == '0);
    // Drain ends on the falling edge where the bit counter wraps
    assign w_stop     = w_fall && w_last && (r_state == DRAIN) && !iEnable;
    assign w_accept   = bus.iValid && r_ready;

    // Left/right samples placed MSB-first at the top of each slot, zero-padded below
    always_comb begin
        w_frame_hold = '0;
        w_frame_hold[FRAME_W-1 -: AUDIO_WS] = r_hold_l;
        w_frame_hold[SLOT_WS-1 -: AUDIO_WS] = r_hold_r;
    end

`ifdef I2S_UNDERRUN_REPEAT_EN
    assign w_payload = r_full ? w_frame_hold : r_last;
`else
    assign w_payload = r_full ? w_frame_hold : '0;
`endif

    // Holding register and registered ready; accept and load may coincide
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_full   <= 1'b0;
            r_ready  <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
`ifdef I2S_UNDERRUN_REPEAT_EN
            r_last   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_hold_l <= bus.iL;
                r_hold_r <= bus.iR;
                r_full   <= 1'b1;
            end else if (w_load) begin
                r_full   <= 1'b0;
            end
            // Ready drops at once on accept but returns one cycle after a load
            r_ready <= !r_full && !w_accept;
`ifdef I2S_UNDERRUN_REPEAT_EN
            if (w_load) begin
                r_last <= w_payload;
            end
`endif
        end
    end

    // Transmit FSM with serialiser; LRCK/DAT only change on BCLK falling edges
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state       <= IDLE;
            r_lrck        <= 1'b1;
            r_dat         <= 1'b0;
            r_shift       <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            case (r_state)
                IDLE:    if (iEnable)  r_state <= RUN;
                RUN:     if (!iEnable) r_state <= DRAIN;
                DRAIN:   if (iEnable)  r_state <= RUN;
                default: r_state <= IDLE;
            endcase
            if (w_stop) begin
                r_state <= IDLE;
                r_lrck  <= 1'b1;
                r_dat   <= 1'b0;
                r_shift <= '0;
            end else if (w_fall) begin
                r_lrck <= (w_cnt_next >= c_cnt_slot);
                if (w_load) begin
                    r_shift       <= w_payload << 1;
                    r_dat         <= w_payload[FRAME_W-1];
                    r_frame_start <= 1'b1;
                    r_underrun    <= !r_full;
                end else begin
                    r_dat   <= r_shift[FRAME_W-1];
                    r_shift <= r_shift << 1;
                end
            end
        end
    end

    assign bus.oReady  = r_ready;
    assign oLRCK       = r_lrck;
    assign oDAT        = r_dat;
    assign oFrameStart = r_frame_start;
    assign oUnderrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
// ============================================================================
// Module   : tb_i2s_master_tx
// Brief    : Directed self-checking bench for i2s_master_tx (default
//            parameters; expectations follow I2S_UNDERRUN_REPEAT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_master_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;
    logic bclk, lrck, dat, fs, ur;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_now  = 0;

    i2s_master_tx_if #(.AUDIO_WS(16)) bus ();

    i2s_master_tx dut (
        .iCLK_50     (clk),
        .iRST_N      (rst_n),
        .iEnable     (en),
        .bus         (bus),
        .oBCLK       (bclk),
        .oLRCK       (lrck),
        .oDAT        (dat),
        .oFrameStart (fs),
        .oUnderrun   (ur)
    );

    always #10 clk = ~clk;

    // Free-running cycle stamp, read on negedges
    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_fs(output logic under, output int t);
        int n = 0;
        @(negedge clk);
        while (!fs && n < 5000) begin @(negedge clk); n++; end
        if (!fs) check("fs_timeout", 0, 1);
        under = ur;
        t = cyc_now;
    endtask

    task automatic wait_falls(input int cnt);
        int got = 0, n = 0;
        logic prev = bclk;
        while (got < cnt && n < 5000) begin
            @(negedge clk); n++;
            if (prev && !bclk) got++;
            prev = bclk;
        end
        if (got < cnt) check("fall_timeout", got, cnt);
    endtask

    // Samples DAT/LRCK on the next 32 BCLK rises
    task automatic capture(output logic [31:0] bits, output logic [31:0] lr, output int fcnt);
        int got = 0, n = 0;
        logic prev = bclk;
        bits = '0; lr = '0; fcnt = 0;
        while (got < 32 && n < 4000) begin
            @(negedge clk); n++;
            if (fs) fcnt++;
            if (bclk && !prev) begin
                bits = {bits[30:0], dat};
                lr   = {lr[30:0], lrck};
                got++;
            end
            prev = bclk;
        end
        if (got < 32) check("capture_timeout", got, 32);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic keep);
        int n = 0;
        bus.iL = l; bus.iR = r; bus.iValid = 1'b1;
        while (!bus.oReady && n < 5000) begin @(negedge clk); n++; end
        if (!bus.oReady) check("ready_timeout", 0, 1);
        @(negedge clk);
        check("ready_drop", bus.oReady, 0);
        if (!keep) bus.iValid = 1'b0;
    endtask

    task automatic reset_release();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_state", {26'd0, bclk, lrck, dat, bus.oReady, fs, ur}, 32'b010000);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.oReady, 1);
    endtask

    task automatic test_basic(output int t);
        logic u; logic [31:0] b, l; int f;
        en = 1'b1;
        send(16'h8001, 16'h7FFE, 1'b0);
        wait_fs(u, t);
        check("t1_underrun", u, 0);
        capture(b, l, f);
        check("t1_data", b, 32'h8001_7FFE);
        check("t1_lrck", l, 32'h0001_FFFE);
        check("t1_fs_once", f, 0);
    endtask

    logic [15:0] fr_l [3] = '{16'hA5C3, 16'h8000, 16'hFFFF};
    logic [15:0] fr_r [3] = '{16'h0F0F, 16'h0001, 16'h5555};

    initial begin
        logic u; logic [31:0] b, l; int f, t0, t1, hi, lo, rises, fsc;
        logic prev;
        bus.iValid = 1'b0; bus.iL = '0; bus.iR = '0;
        #1 rst_n = 1'b0;

        // Reset, basic frame, then underrun with period check
        reset_release();
        test_basic(t0);
        wait_fs(u, t1);
        check("frame_period", t1 - t0, 1024);
        check("underrun_after_t1", u, 1);
        capture(b, l, f);
`ifdef I2S_UNDERRUN_REPEAT_EN
        check("underrun_payload_t1", b, 32'h8001_7FFE);
`else
        check("underrun_payload_t1", b, 32'h0);
`endif

        // BCLK high and low times
        prev = bclk; hi = 0; lo = 0;
        for (int i = 0; i < 200 && !(bclk && !prev); i++) begin prev = bclk; @(negedge clk); end
        for (int i = 0; i < 200 && bclk; i++) begin hi++; @(negedge clk); end
        for (int i = 0; i < 200 && !bclk; i++) begin lo++; @(negedge clk); end
        check("bclk_high", hi, 16);
        check("bclk_low", lo, 16);

        // Back-to-back frames with valid held high
        wait_fs(u, t0);
        fork
            begin
                send(fr_l[0], fr_r[0], 1'b1);
                send(fr_l[1], fr_r[1], 1'b1);
                send(fr_l[2], fr_r[2], 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    logic uk; logic [31:0] bk, lk; int fk, tk;
                    wait_fs(uk, tk);
                    check("b2b_underrun", uk, 0);
                    check("b2b_ready_at_fs", bus.oReady, 0);
                    @(negedge clk);
                    check("b2b_ready_after_fs", bus.oReady, 1);
                    capture(bk, lk, fk);
                    check("b2b_data", bk, {fr_l[k], fr_r[k]});
                    check("b2b_fs_once", fk, 0);
                end
            end
        join

        // Single frame then underrun
        send(16'h1234, 16'h0000, 1'b0);
        wait_fs(u, t0);
        check("ur_first_underrun", u, 0);
        capture(b, l, f);
        check("ur_first_data", b, 32'h1234_0000);
        wait_fs(u, t0);
        check("ur_flag", u, 1);
        capture(b, l, f);
`ifdef I2S_UNDERRUN_REPEAT_EN
        check("ur_payload", b, 32'h1234_0000);
`else
        check("ur_payload", b, 32'h0);
`endif

        // Disable at bitCnt=5: rises for bitCnt 5..31 remain, then idle
        wait_fs(u, t0);
        wait_falls(4);
        en = 1'b0;
        rises = 0; fsc = 0; prev = bclk;
        repeat (1500) begin
            @(negedge clk);
            if (bclk && !prev) rises++;
            if (fs) fsc++;
            prev = bclk;
        end
        check("drain_rises", rises, 27);
        check("drain_no_load", fsc, 0);
        check("idle_outputs", {29'd0, bclk, lrck, dat}, 32'b010);

        // Asynchronous reset at bitCnt=20, then the basic test again
        en = 1'b1;
        wait_fs(u, t0);
        wait_falls(19);
        @(posedge clk);
        #3 rst_n = 1'b0; en = 1'b0;
        #1 check("async_reset", {26'd0, bclk, lrck, dat, bus.oReady, fs, ur}, 32'b010000);
        reset_release();
        test_basic(t0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
